// File: rtl/bcd_xs3_serial_conv.sv
// ============================================================================
// Module   : bcd_xs3_serial_conv
// Purpose  : Multi-digit BCD <-> excess-3 converter, one digit per clock,
//            LSB digit first, with per-digit invalid flags and valid/ready
//            handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_xs3_serial_conv #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     err,
  output logic                  any_err,
  output logic                  busy
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [4*DIGITS-1:0]  src;
  logic                 mode_r;
  logic [IDX_W-1:0]     idx;
  logic [3:0]           digit;
  logic [3:0]           result;
  logic                 digit_err;

  // Status outputs decode only registered state, never the handshake inputs
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CONV) || (state == DONE);
  assign any_err   = |err;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, walk digits in CONV, hold result in DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)          state_nxt = CONV;
      CONV:    if (idx == LAST_IDX)   state_nxt = DONE;
      DONE:    if (out_ready)         state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Convert the currently selected digit; invalid digits pass through untouched
  always_comb begin
    digit     = src[{idx, 2'b00} +: 4];
    result    = digit;
    digit_err = 1'b0;
    if (!mode_r) begin
      if (digit <= 4'd9) result = digit + 4'd3;
      else               digit_err = 1'b1;
    end else begin
      if ((digit >= 4'd3) && (digit <= 4'd12)) result = digit - 4'd3;
      else                                     digit_err = 1'b1;
    end
  end

  // Datapath: capture the word, then build the result one digit per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src      <= '0;
      mode_r   <= 1'b0;
      idx      <= '0;
      out_data <= '0;
      err      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            src    <= in_data;
            mode_r <= mode;
            err    <= '0;
            idx    <= '0;
          end
        end
        CONV: begin
          out_data[{idx, 2'b00} +: 4] <= result;
          if (digit_err)        err[idx] <= 1'b1;
          if (idx != LAST_IDX)  idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
